// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and width helpers for the data memory controller and its byte-lane merge.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int BYTE_W     = 8;
  localparam int WAIT_CNT_W = 4;

  // Lane 0 is the most-significant byte of the word.
  localparam bit LANE_BIG_ENDIAN = 1'b1;

  function automatic int lanes_of(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic int idx_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int off_w_of(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 0;
  endfunction

  function automatic int lane_lsb(input int lane, input int lanes);
    return LANE_BIG_ENDIAN ? (lanes - 1 - lane) * BYTE_W : lane * BYTE_W;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_bytelane_merge.sv
// Combinational byte-lane merge: lanes with sel set take wdata, the rest keep the old word.
module mem_bytelane_merge
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = DATA_W / BYTE_W
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [0:LANES-1]  sel,
  output logic [DATA_W-1:0] new_word
);

  always_comb begin
    new_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (sel[i]) begin
        new_word[lane_lsb(i, LANES) +: BYTE_W] = wdata[lane_lsb(i, LANES) +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Synchronous data memory with valid/ready requests, configurable wait states,
// byte-lane writes, out-of-range error responses and a post-reset clear sweep.
//
// Handshake: a request is accepted on a rising edge where req_valid and req_ready
// are both high; req_ready is a registered state decode (high only in IDLE) and
// never depends on req_valid. Each accept produces exactly one single-cycle
// rsp_valid pulse, with rsp_rdata/rsp_err qualified by it and 0 otherwise.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2048,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0,
  parameter int LANES       = lanes_of(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [0:LANES-1]  req_sel,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done,
  output state_t            dbg_state
);

  localparam int IDX_W    = idx_w_of(DEPTH);
  localparam int OFF_W    = off_w_of(LANES);
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

  state_t                  state;
  logic [IDX_W-1:0]        cnt;
  logic [WAIT_CNT_W-1:0]   wait_cnt;

  logic                    lat_we;
  logic [IDX_W-1:0]        lat_idx;
  logic [DATA_W-1:0]       lat_wdata;
  logic [0:LANES-1]        lat_sel;
  logic                    lat_err;

  logic [ADDR_W-1:0]       word_addr;
  logic [IDX_W-1:0]        req_idx;
  logic                    req_err;

  logic                    op_we;
  logic [IDX_W-1:0]        op_idx;
  logic [DATA_W-1:0]       op_wdata;
  logic [0:LANES-1]        op_sel;
  logic                    op_err;

  logic                    accept;
  logic                    commit;
  logic [DATA_W-1:0]       rd_word;
  logic [DATA_W-1:0]       merged_word;

  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;

  logic [DATA_W-1:0]       mem [DEPTH];

  assign dbg_state = state;

  // Byte offset bits are dropped; anything above the index field is out of range.
  assign word_addr = req_addr >> OFF_W;
  assign req_idx   = word_addr[IDX_W-1:0];
  assign req_err   = (word_addr >> IDX_W) != '0;

  assign accept = req_valid & req_ready;

  // With no wait states the access happens on the accept edge itself, so the
  // operands come straight from the request; otherwise from the latched copy.
  always_comb begin
    op_we    = lat_we;
    op_idx   = lat_idx;
    op_wdata = lat_wdata;
    op_sel   = lat_sel;
    op_err   = lat_err;
    if (state == ST_IDLE) begin
      op_we    = req_we;
      op_idx   = req_idx;
      op_wdata = req_wdata;
      op_sel   = req_sel;
      op_err   = req_err;
    end
  end

  assign commit = ((state == ST_IDLE) && accept && !HAS_WAIT) ||
                  ((state == ST_WAIT) && (wait_cnt == WAIT_CNT_W'(1)));

  assign rd_word = mem[op_idx];

  mem_bytelane_merge #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_merge (
    .old_word (rd_word),
    .wdata    (op_wdata),
    .sel      (op_sel),
    .new_word (merged_word)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = op_idx;
    mem_wdata = merged_word;
    if (!rst) begin
      if (state == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = '0;
      end else if (commit && op_we && !op_err) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_sel   <= '0;
      lat_err   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;

      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            lat_sel   <= req_sel;
            lat_err   <= req_err;
            req_ready <= 1'b0;
            if (HAS_WAIT) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_CNT_W'(1)) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase

      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_we) ? '0 : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (32-bit words, 16 deep, 2 wait states).
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int WC  = 2;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [0:3]    req_sel = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [DEP];
  logic [DW-1:0] exp_q[$];
  logic          err_q[$];
  int            acc_q[$];

  data_mem_ctrl #(
    .DATA_W      (DW),
    .DEPTH       (DEP),
    .ADDR_W      (AW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEP; i++) model[i] = '0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();  // the init sweep zeroes every word
  endtask

  // ---------------- reference model ----------------
  function automatic void predict(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [0:3] sel,
                                  output logic [31:0] rd, output logic er);
    int unsigned idx;
    logic [7:0]  b [4];
    idx = addr / 4;
    rd  = '0;
    er  = (idx >= DEP);
    if (er) return;
    if (!we) begin
      rd = model[idx];
      return;
    end
    // b[0] is the most significant byte, matching lane 0
    b[0] = model[idx][31:24];
    b[1] = model[idx][23:16];
    b[2] = model[idx][15:8];
    b[3] = model[idx][7:0];
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) b[i] = 8'((wdata >> (24 - 8 * i)) & 32'hFF);
    end
    model[idx] = {b[0], b[1], b[2], b[3]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_expect();
    logic [31:0] rd;
    logic        er;
    predict(req_we, req_addr, req_wdata, req_sel, rd, er);
    exp_q.push_back(rd);
    err_q.push_back(er);
  endtask

  task automatic wait_ready(input string name, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [0:3] sel);
    bit ok;
    @(posedge clk); #1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
    req_valid = 1'b1;
    wait_ready("req", ok);
    if (ok) push_expect();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rand_fields();
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 32'($urandom_range(0, 'h47));
    req_wdata = $urandom;
    req_sel   = 4'($urandom_range(0, 15));
  endtask

  task automatic burst(input int n);
    bit ok;
    @(posedge clk); #1;
    rand_fields();
    req_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_ready("burst", ok);
      if (!ok) break;
      push_expect();
      @(posedge clk); #1;
      rand_fields();
    end
    req_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic rst_e = 1'b1;
  int   cyc = 0;
  int   since = 0;
  int   last_acc = 0;
  bit   have_prev = 1'b0;
  bit   run_ok = 1'b0;

  always @(posedge clk) rst_e = rst;

  always @(negedge clk) begin
    cyc++;
    if (rst_e) begin
      chk("rst_ctrl", {28'd0, req_ready, rsp_valid, rsp_err, init_done}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_state", 32'(dbg_state == ST_INIT), 32'd1);
      exp_q.delete();
      err_q.delete();
      acc_q.delete();
      since     = 0;
      have_prev = 1'b0;
      run_ok    = 1'b0;
    end else begin
      since++;
      chk("init_done", 32'(init_done), 32'(since >= DEP));
      chk("req_ready", 32'(req_ready), 32'((since >= DEP) && (acc_q.size() == 0)));
      if (!req_valid) run_ok = 1'b0;
      if (req_valid && req_ready) begin
        if (run_ok && have_prev) chk("accept_spacing", 32'(cyc - last_acc), 32'(WC + 2));
        last_acc  = cyc;
        have_prev = 1'b1;
        run_ok    = 1'b1;
        acc_q.push_back(cyc);
      end
      if (rsp_valid) begin
        if (acc_q.size() == 0 || exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          chk("latency", 32'(cyc - acc_q.pop_front()), 32'(WC + 1));
          chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
          chk("rsp_err", 32'(rsp_err), 32'(err_q.pop_front()));
        end
      end else begin
        chk("idle_rsp", {31'd0, rsp_err} | rsp_rdata, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    clear_model();
    do_reset(3);

    for (int a = 0; a < DEP; a++) do_req(1'b0, 32'(a * 4), 32'd0, 4'b0000);

    do_req(1'b1, 32'h08, 32'hDEADBEEF, 4'b1111);
    do_req(1'b0, 32'h08, 32'd0, 4'b0000);
    do_req(1'b1, 32'h08, 32'h11223344, 4'b0101);
    do_req(1'b0, 32'h08, 32'd0, 4'b1111);
    do_req(1'b1, 32'h0C, 32'hCAFEF00D, 4'b0000);
    do_req(1'b0, 32'h0F, 32'd0, 4'b0000);

    do_req(1'b1, 32'h40, 32'hFFFFFFFF, 4'b1111);
    do_req(1'b0, 32'h40, 32'd0, 4'b1111);
    do_req(1'b0, 32'h00, 32'd0, 4'b1111);
    do_req(1'b1, 32'h80000008, 32'hA5A5A5A5, 4'b1111);
    do_req(1'b0, 32'h80000008, 32'd0, 4'b1111);
    do_req(1'b0, 32'h3C, 32'd0, 4'b1111);

    burst(12);

    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h4B)), $urandom,
             4'($urandom_range(0, 15)));
    end

    // reset while a write to 0x04 sits in its wait states
    @(posedge clk); #1;
    req_we    = 1'b1;
    req_addr  = 32'h04;
    req_wdata = 32'h0BADF00D;
    req_sel   = 4'b1111;
    req_valid = 1'b1;
    wait_ready("midop", ok);
    if (ok) push_expect();
    @(posedge clk); #1;
    req_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (dbg_state == ST_WAIT) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midop_reached_wait", 32'(ok), 32'd1);
    do_reset(2);
    do_req(1'b0, 32'h04, 32'd0, 4'b1111);
    do_req(1'b0, 32'h08, 32'd0, 4'b1111);

    for (int t = 0; t < 50 && acc_q.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised synchronous data memory for the CPU data port and testbenches. Adds a clocked valid/ready request with configurable wait states and a one-cycle response pulse. Supports per-byte-lane writes and an out-of-range error response. After reset, an init sweep clears the array at one word per cycle.

Parameters:
DATA_W, 32, word width in bits; multiple of 8.
DEPTH, 2048, number of words; power of two.
ADDR_W, 32, byte-address width.
WAIT_CYCLES, 0, extra cycles between request accept and response (0..15).
LANES, DATA_W/8, derived; number of byte lanes.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address; word index = req_addr >> log2(LANES)
req_wdata  in  DATA_W  write data
req_sel  in  LANES  byte-lane enables; sel[0] = most-significant byte (big-endian lane order)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  qualified by rsp_valid; word index >= DEPTH
init_done  out  1  high once the clear sweep has completed

Behaviour:
- Reset is synchronous and active-high. While rst is high and in the cycle after it falls, outputs are:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - The FSM is in INIT and the sweep counter is 0.
- FSM states are INIT, IDLE, WAIT and RESP.
- INIT:
  - Writes 0 to word[cnt] each cycle and increments cnt.
  - After word DEPTH-1 is written, goes to IDLE and sets init_done=1.
  - INIT lasts exactly DEPTH cycles; requests are ignored (req_ready=0).
- IDLE:
  - req_ready=1.
  - Accept occurs on the cycle where req_valid & req_ready.
  - On accept, latch we, word index, wdata, sel and the range check.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- WAIT:
  - req_ready=0.
  - Down-counter is loaded with WAIT_CYCLES; go to RESP when it reaches 1.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - req_ready=0 in RESP, so back-to-back requests are spaced WAIT_CYCLES+2 cycles apart.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
- Writes:
  - The array is updated at the RESP-entry edge.
  - Lane i is replaced by wdata lane i only where sel[i]=1; other lanes are preserved.
  - sel=0 is a legal no-op write with rsp_err=0.
- Reads:
  - rsp_rdata is the full word read at RESP, regardless of sel.
  - A read issued after a write to the same word returns the written data.
- Range check:
  - The error condition is word index >= DEPTH, i.e. any nonzero upper address bits above the index.
  - On error: no array access, rsp_err=1, rsp_rdata=0.
- Low address bits below the lane boundary are ignored (no alignment check).
- rsp_rdata and rsp_err return to 0 when rsp_valid is low.
- Reset in any state abandons the pending request and restarts INIT. No response is produced for the abandoned request; any write not yet committed is lost.
- Ready is not speculative: req_ready is a registered state decode, with no combinational path from req_valid.

Decomposition:
- Shared package holds:
  - the state enum {INIT, IDLE, WAIT, RESP};
  - LANES and index-width derivations (clog2);
  - the lane-ordering constant (big-endian).
- One sub-module, mem_bytelane_merge: combinational merge of old word, wdata and sel into the new word. It is reused by the future cache fill path.
- The array itself stays inline as a single inferred reg array.

Test Plan:
All cases use DATA_W=32, DEPTH=16, WAIT_CYCLES=2.
- Reset/init:
  - Stimulus: rst high 3 cycles, then low.
  - Required: init_done=0 and req_ready=0 for 16 cycles, then both go to 1; a read of every address 0x00..0x3C returns 0x00000000.
- Full write/read:
  - Stimulus: write addr 0x08, data 0xDEADBEEF, sel=4'b1111; then read 0x08.
  - Required: rsp_valid arrives 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
- Byte lanes:
  - Stimulus: starting from 0xDEADBEEF at 0x08, write 0x11223344 with sel=4'b0101.
  - Required: a read of 0x08 returns 0xDE22BE44.
- Out of range:
  - Stimulus: write 0x40 with 0xFFFFFFFF, then read 0x40.
  - Required: both responses have rsp_err=1 and rdata=0; a read of 0x00 still returns 0.
- Handshake spacing:
  - Stimulus: req_valid held high continuously.
  - Required: accepts occur every 4 cycles; req_ready is low during WAIT/RESP; each accept gets exactly one rsp_valid.
- Reset mid-op:
  - Stimulus: assert rst during WAIT of a write to 0x04.
  - Required: no rsp_valid; INIT reruns; a read of 0x04 returns 0.
